// File: rtl/bsg_downstream_token_rx.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_downstream_token_rx
//  Purpose  : Receive end of the token/data link. It assembles channel beats
//             into core words, queues them, and returns credits as token
//             toggles.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_downstream_token_rx #(
    parameter int CH_WIDTH    = 8,
    parameter int CHANNELS    = 2,
    parameter int CORE_WIDTH  = 64,
    parameter int FIFO_ELS    = 16,
    parameter int TOKEN_BATCH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           io_valid_i,
    input  logic [CH_WIDTH*CHANNELS-1:0]   io_data_i,
    output logic                           io_token_o,
    output logic                           core_valid_o,
    output logic [CORE_WIDTH-1:0]          core_data_o,
    input  logic                           core_yumi_i,
    output logic                           overflow_o,
    output logic [$clog2(TOKEN_BATCH)-1:0] credit_pend_o
);

    localparam int BW    = CH_WIDTH * CHANNELS;
    localparam int BEATS = CORE_WIDTH / BW;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_ELS);
    localparam int TB_W  = $clog2(TOKEN_BATCH);

    localparam logic [BC_W-1:0] C_LAST_BEAT  = BC_W'(BEATS - 1);
    localparam logic [TB_W-1:0] C_LAST_CRED  = TB_W'(TOKEN_BATCH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BC_W-1:0]       beat_cnt_q,  beat_cnt_d;
    logic [CORE_WIDTH-1:0] partial_q,   partial_d;
    logic [AW:0]           wr_ptr_q,    wr_ptr_d;
    logic [AW:0]           rd_ptr_q,    rd_ptr_d;
    logic [TB_W-1:0]       dq_cnt_q,    dq_cnt_d;
    logic                  token_q,     token_d;
    logic                  overflow_q,  overflow_d;

    logic [CORE_WIDTH-1:0] mem_q [FIFO_ELS];

    logic [CORE_WIDTH-1:0] word_w;
    logic                  last_beat_w;
    logic                  empty_w;
    logic                  full_w;
    logic                  deq_w;
    logic                  enq_w;

    // ------------------------------------------------------------------
    // Deserializer: the arriving beat is merged into its slot so the
    // completed word is available on the same cycle as the last beat.
    // ------------------------------------------------------------------
    always_comb begin
        word_w = partial_q;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_cnt_q == BC_W'(i)) begin
                word_w[i*BW +: BW] = io_data_i;
            end
        end
    end

    assign last_beat_w = io_valid_i && (beat_cnt_q == C_LAST_BEAT);

    // ------------------------------------------------------------------
    // FIFO status and handshake
    // ------------------------------------------------------------------
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign deq_w   = core_yumi_i && !empty_w;
    // A simultaneous dequeue frees the slot, so a full FIFO still accepts.
    assign enq_w   = last_beat_w && (!full_w || deq_w);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        partial_d  = partial_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dq_cnt_d   = dq_cnt_q;
        token_d    = token_q;
        overflow_d = overflow_q;

        if (io_valid_i) begin
            partial_d = word_w;
            if (beat_cnt_q == C_LAST_BEAT) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        if (enq_w) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (last_beat_w && full_w && !deq_w) begin
            overflow_d = 1'b1;
        end

        if (deq_w) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dq_cnt_d = dq_cnt_q + 1'b1;
            if (dq_cnt_q == C_LAST_CRED) begin
                token_d = ~token_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            partial_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dq_cnt_q   <= '0;
            token_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            partial_q  <= partial_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dq_cnt_q   <= dq_cnt_d;
            token_q    <= token_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (enq_w && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= word_w;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign core_valid_o  = !empty_w;
    assign core_data_o   = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign io_token_o    = token_q;
    assign overflow_o    = overflow_q;
    assign credit_pend_o = dq_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_downstream_token_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_downstream_token_rx
//  Purpose  : Directed self-checking bench for bsg_downstream_token_rx.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_downstream_token_rx;

    logic        clk;
    logic        rst;
    logic        io_valid_i;
    logic [15:0] io_data_i;
    logic        io_token_o;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_yumi_i;
    logic        overflow_o;
    logic [2:0]  credit_pend_o;

    int n_chk;
    int n_err;
    int n_deq;
    logic [63:0] model_q[$];
    logic [63:0] exp_w;

    bsg_downstream_token_rx dut (
        .clk           (clk),
        .rst           (rst),
        .io_valid_i    (io_valid_i),
        .io_data_i     (io_data_i),
        .io_token_o    (io_token_o),
        .core_valid_o  (core_valid_o),
        .core_data_o   (core_data_o),
        .core_yumi_i   (core_yumi_i),
        .overflow_o    (overflow_o),
        .credit_pend_o (credit_pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; io_valid_i = 1'b0; io_data_i = '0; core_yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_deq = 0;
        model_q.delete();
    endtask

    task automatic beat(input logic [15:0] d, input logic yumi);
        io_valid_i = 1'b1; io_data_i = d; core_yumi_i = yumi;
        @(posedge clk);
        #1 io_valid_i = 1'b0; core_yumi_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic deq();
        core_yumi_i = 1'b1;
        @(posedge clk);
        #1 core_yumi_i = 1'b0;
    endtask

    function automatic logic [63:0] word_of(input logic [7:0] k);
        return {k, 8'h04, k, 8'h03, k, 8'h02, k, 8'h01};
    endfunction

    task automatic send_word(input logic [7:0] k, input logic yumi_last);
        beat({k, 8'h01}, 1'b0);
        beat({k, 8'h02}, 1'b0);
        beat({k, 8'h03}, 1'b0);
        beat({k, 8'h04}, yumi_last);
    endtask

    initial begin
        n_chk = 0; n_err = 0; n_deq = 0;

        // Test 1: reset state and back-to-back beats
        do_reset();
        check("rst_valid",    64'(core_valid_o),  64'd0);
        check("rst_data",     core_data_o,        64'd0);
        check("rst_token",    64'(io_token_o),    64'd0);
        check("rst_ovf",      64'(overflow_o),    64'd0);
        check("rst_pend",     64'(credit_pend_o), 64'd0);
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b0);
        beat(16'h3333, 1'b0);
        check("t1_partial_valid", 64'(core_valid_o), 64'd0);
        beat(16'h4444, 1'b0);
        check("t1_valid", 64'(core_valid_o), 64'd1);
        check("t1_data",  core_data_o, 64'h4444_3333_2222_1111);

        // Test 2: gaps between beats
        do_reset();
        beat(16'h1111, 1'b0); idle(2);
        beat(16'h2222, 1'b0); idle(3);
        beat(16'h3333, 1'b0); idle(1);
        check("t2_gap_valid", 64'(core_valid_o), 64'd0);
        beat(16'h4444, 1'b0);
        check("t2_data", core_data_o, 64'h4444_3333_2222_1111);
        idle(3);
        deq();
        check("t2_single_word", 64'(core_valid_o), 64'd0);
        check("t2_pend",        64'(credit_pend_o), 64'd1);
        deq();
        check("t2_empty_yumi_pend", 64'(credit_pend_o), 64'd1);

        // Test 3/4: fill, full-with-dequeue, then overflow
        do_reset();
        for (int k = 0; k < 16; k++) begin
            send_word(8'(k), 1'b0);
            model_q.push_back(word_of(8'(k)));
        end
        check("t3_full_ovf",  64'(overflow_o), 64'd0);
        check("t3_full_head", core_data_o, word_of(8'd0));
        send_word(8'd16, 1'b1);
        void'(model_q.pop_front());
        model_q.push_back(word_of(8'd16));
        n_deq++;
        check("t4_no_ovf", 64'(overflow_o), 64'd0);
        check("t4_head",   core_data_o, word_of(8'd1));
        send_word(8'd17, 1'b0);
        check("t3_ovf",       64'(overflow_o), 64'd1);
        check("t3_ovf_head",  core_data_o, word_of(8'd1));

        // Drain 16 words, checking order and credit return
        for (int i = 0; i < 16; i++) begin
            exp_w = model_q.pop_front();
            check($sformatf("drain_head_%0d", i), core_data_o, exp_w);
            deq();
            n_deq++;
            check($sformatf("drain_pend_%0d", i),  64'(credit_pend_o), 64'(n_deq % 8));
            check($sformatf("drain_token_%0d", i), 64'(io_token_o),    64'((n_deq / 8) % 2));
        end
        check("drain_empty", 64'(core_valid_o), 64'd0);
        check("ovf_sticky",  64'(overflow_o),   64'd1);

        // Test 5: exact toggle points from reset
        do_reset();
        for (int k = 0; k < 16; k++) send_word(8'(k + 32), 1'b0);
        for (int i = 0; i < 7; i++) deq();
        check("t5_pend7",   64'(credit_pend_o), 64'd7);
        check("t5_tok_pre", 64'(io_token_o),    64'd0);
        deq();
        check("t5_tok_8",   64'(io_token_o),    64'd1);
        check("t5_pend0",   64'(credit_pend_o), 64'd0);
        for (int i = 0; i < 8; i++) deq();
        check("t5_tok_16",  64'(io_token_o),    64'd0);
        check("t5_empty",   64'(core_valid_o),  64'd0);

        // Test 6: reset mid-word and mid-batch
        do_reset();
        for (int k = 0; k < 3; k++) send_word(8'(k + 64), 1'b0);
        deq(); deq(); deq();
        check("t6_pend3", 64'(credit_pend_o), 64'd3);
        beat(16'hDEAD, 1'b0);
        beat(16'hBEEF, 1'b0);
        do_reset();
        check("t6_rst_pend",  64'(credit_pend_o), 64'd0);
        check("t6_rst_token", 64'(io_token_o),    64'd0);
        check("t6_rst_valid", 64'(core_valid_o),  64'd0);
        beat(16'hA1A1, 1'b0);
        beat(16'hB2B2, 1'b0);
        beat(16'hC3C3, 1'b0);
        beat(16'hD4D4, 1'b0);
        check("t6_fresh_valid", 64'(core_valid_o), 64'd1);
        check("t6_fresh_data",  core_data_o, 64'hD4D4_C3C3_B2B2_A1A1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
